instruction_phase_sequencer: RTL and testbench
==============================================

Name: instruction_phase_sequencer

Overview:
Central CPU phase controller. Generates the one-hot FETCH/DECODE/EXECUTE/COMMIT strobes consumed by all group decoders, including the jump group decoder. Stretches the FETCH and EXECUTE phases while the memory bus is busy, and times out stuck bus cycles. Arbitrates between continuing to the next instruction, taking an interrupt and halting, with that decision made at the end of COMMIT.

Parameters:
WAIT_TIMEOUT, 15, consecutive BUS_WAIT cycles tolerated in one phase before bus error (range 1..255)
COUNT_W, 16, width of retired-instruction counter

Ports:
CLK  input  1  system clock, rising edge
RESET  input  1  asynchronous, active-low reset
BUS_WAIT  input  1  memory not ready; stretches the current bus phase
MEM_RD  input  1  current instruction needs an operand read in EXECUTE (RDX from group decoders)
IRQ  input  1  level interrupt request
IE  input  1  interrupt enable flag
HALT_REQ  input  1  request halt after current instruction
RUN  input  1  leave HALT / clear bus error
FETCH  output  1  fetch phase strobe
DECODE  output  1  decode phase strobe
EXECUTE  output  1  execute phase strobe
COMMIT  output  1  commit phase strobe
IR_LOAD  output  1  latch instruction register this cycle
INT_ACK  output  1  interrupt acknowledge, one-cycle pulse
HALTED  output  1  core halted
BUS_ERR  output  1  sticky bus timeout flag
INSTR_COUNT  output  COUNT_W  retired-instruction count

Behaviour:
Reset:
- RESET low, asynchronously: state=RST, all outputs 0, wait counter 0, INSTR_COUNT 0.
- The first rising CLK edge with RESET high moves to FETCH.
- Reset asserted mid-phase aborts immediately. There is no partial commit.

Output timing:
- Phase strobes are decoded from registered one-hot state. Moore, glitch-free.
- At most one of FETCH/DECODE/EXECUTE/COMMIT is high in any cycle.
- All strobes are low in RST, INTR and HALT.

State transitions:
- FETCH:
  - BUS_WAIT=1: stay, wait counter +1.
  - BUS_WAIT=0: IR_LOAD=1 (combinational with the FETCH state and !BUS_WAIT), clear counter, next state DECODE.
- DECODE: exactly 1 cycle, then EXECUTE.
- EXECUTE:
  - MEM_RD=1 and BUS_WAIT=1: stay, counter +1.
  - Otherwise: clear counter, next state COMMIT.
  - BUS_WAIT is ignored when MEM_RD=0.
- COMMIT: 1 cycle. INSTR_COUNT +1, wraps modulo 2^COUNT_W. Next state by priority:
  1. IRQ&IE -> INTR
  2. HALT_REQ -> HALT
  3. otherwise -> FETCH
- INTR: 1 cycle, INT_ACK=1, then FETCH.
- HALT: HALTED=1.
  - IRQ&IE -> INTR (HALTED drops the same edge).
  - Else RUN=1 -> FETCH.
  - IRQ&IE wins over RUN.

Bus timeout:
- Wait counter reaching WAIT_TIMEOUT while BUS_WAIT is still 1 sets BUS_ERR, clears the counter and goes to HALT.
- The instruction is not committed and INSTR_COUNT is unchanged.
- BUS_ERR is sticky and is cleared only by RUN in HALT.
- While BUS_ERR=1, IRQ does not leave HALT.

Latency:
- Minimum 4 cycles per instruction (F,D,E,C).
- Plus the number of wait cycles.
- Plus 1 when an interrupt is taken.

Other rules:
- IRQ, HALT_REQ and RUN are sampled only in the states listed above and ignored elsewhere. There is no queuing.
- Simultaneous RUN and HALT_REQ at COMMIT: HALT_REQ wins, because RUN is only sampled in HALT.

Decomposition:
- Shared constants file: state encodings (SEQ_RST, SEQ_FETCH, SEQ_DECODE, SEQ_EXECUTE, SEQ_COMMIT, SEQ_INTR, SEQ_HALT), one-hot width, default WAIT_TIMEOUT.
- One natural sub-module, bus_wait_timer:
  - Inputs: CLK, RESET, CLR, INC.
  - Output: EXPIRED.
  - 8-bit counter that compares against WAIT_TIMEOUT.
- Phase FSM and retired-instruction counter stay in the top module.

Test Plan:
- Reset release, BUS_WAIT=0, MEM_RD=0: strobes F,D,E,C repeat with period 4. IR_LOAD high on each FETCH cycle. INSTR_COUNT=3 after 12 cycles.
- FETCH with BUS_WAIT high 3 cycles: FETCH held 4 cycles, IR_LOAD only in the 4th. DECODE follows one cycle later.
- MEM_RD=1, BUS_WAIT high in EXECUTE 2 cycles: EXECUTE held 3 cycles. With MEM_RD=0 and BUS_WAIT=1, EXECUTE lasts 1 cycle.
- IRQ=1, IE=1, HALT_REQ=1 during COMMIT: INTR entered, INT_ACK pulses 1 cycle, then FETCH. HALTED stays 0.
- HALT_REQ at COMMIT: HALTED=1 and strobes low. RUN=1 one cycle later -> FETCH next cycle. IRQ with IE=0 in HALT -> no exit.
- WAIT_TIMEOUT=4 and BUS_WAIT stuck high in FETCH: BUS_ERR=1 after the 4th wait cycle, HALT entered, INSTR_COUNT unchanged. RUN clears BUS_ERR and resumes FETCH. RESET low mid-EXECUTE zeroes all outputs asynchronously.

Source files
------------

// File: rtl/instruction_phase_sequencer_pkg.sv
// Shared encodings for the instruction phase sequencer.
// State vector is one-hot so phase strobes come straight from flops.
package instruction_phase_sequencer_pkg;

  localparam int SEQ_ONEHOT_W = 7;
  localparam int SEQ_WAIT_W = 8;
  localparam int SEQ_WAIT_TIMEOUT_DEF = 15;

  localparam int SEQ_RST_BIT = 0;
  localparam int SEQ_FETCH_BIT = 1;
  localparam int SEQ_DECODE_BIT = 2;
  localparam int SEQ_EXECUTE_BIT = 3;
  localparam int SEQ_COMMIT_BIT = 4;
  localparam int SEQ_INTR_BIT = 5;
  localparam int SEQ_HALT_BIT = 6;

  typedef enum logic [SEQ_ONEHOT_W-1:0] {
    SEQ_RST     = 7'b000_0001,
    SEQ_FETCH   = 7'b000_0010,
    SEQ_DECODE  = 7'b000_0100,
    SEQ_EXECUTE = 7'b000_1000,
    SEQ_COMMIT  = 7'b001_0000,
    SEQ_INTR    = 7'b010_0000,
    SEQ_HALT    = 7'b100_0000
  } seq_state_e;

endpackage

// File: rtl/instruction_phase_sequencer_bus_wait_timer.sv
// Bus wait-cycle counter; EXPIRED flags the wait cycle that
// would bring the count up to WAIT_TIMEOUT.
module instruction_phase_sequencer_bus_wait_timer
  import instruction_phase_sequencer_pkg::*;
#(
  parameter int WAIT_TIMEOUT = SEQ_WAIT_TIMEOUT_DEF
) (
  input  logic CLK,
  input  logic RESET,
  input  logic CLR,
  input  logic INC,
  output logic EXPIRED
);

  localparam logic [SEQ_WAIT_W-1:0] LIMIT =
    SEQ_WAIT_W'(WAIT_TIMEOUT - 1);

  logic [SEQ_WAIT_W-1:0] cnt_q;
  logic [SEQ_WAIT_W-1:0] cnt_d;

  assign EXPIRED = INC && (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (CLR) begin
      cnt_d = '0;
    end else if (INC) begin
      cnt_d = cnt_q + SEQ_WAIT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/instruction_phase_sequencer.sv
// CPU phase controller: F/D/E/C strobes, bus-wait stretching,
// bus timeout, and commit-time interrupt/halt arbitration.
module instruction_phase_sequencer
  import instruction_phase_sequencer_pkg::*;
#(
  parameter int WAIT_TIMEOUT = SEQ_WAIT_TIMEOUT_DEF,
  parameter int COUNT_W = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               BUS_WAIT,
  input  logic               MEM_RD,
  input  logic               IRQ,
  input  logic               IE,
  input  logic               HALT_REQ,
  input  logic               RUN,
  output logic               FETCH,
  output logic               DECODE,
  output logic               EXECUTE,
  output logic               COMMIT,
  output logic               IR_LOAD,
  output logic               INT_ACK,
  output logic               HALTED,
  output logic               BUS_ERR,
  output logic [COUNT_W-1:0] INSTR_COUNT
);

  seq_state_e         state_q;
  seq_state_e         state_d;
  logic               err_q;
  logic               err_d;
  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;

  logic wait_clr;
  logic wait_inc;
  logic wait_exp;
  logic irq_take;

  instruction_phase_sequencer_bus_wait_timer #(
    .WAIT_TIMEOUT(WAIT_TIMEOUT)
  ) u_timer (
    .CLK    (CLK),
    .RESET  (RESET),
    .CLR    (wait_clr),
    .INC    (wait_inc),
    .EXPIRED(wait_exp)
  );

  assign irq_take = IRQ && IE;

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    count_d  = count_q;
    wait_clr = 1'b1;
    wait_inc = 1'b0;
    unique case (state_q)
      SEQ_RST: begin
        state_d = SEQ_FETCH;
      end
      SEQ_FETCH: begin
        if (BUS_WAIT) begin
          wait_inc = 1'b1;
          wait_clr = wait_exp;
          if (wait_exp) begin
            err_d   = 1'b1;
            state_d = SEQ_HALT;
          end
        end else begin
          state_d = SEQ_DECODE;
        end
      end
      SEQ_DECODE: begin
        state_d = SEQ_EXECUTE;
      end
      SEQ_EXECUTE: begin
        if (MEM_RD && BUS_WAIT) begin
          wait_inc = 1'b1;
          wait_clr = wait_exp;
          if (wait_exp) begin
            err_d   = 1'b1;
            state_d = SEQ_HALT;
          end
        end else begin
          state_d = SEQ_COMMIT;
        end
      end
      SEQ_COMMIT: begin
        count_d = count_q + COUNT_W'(1);
        if (irq_take) begin
          state_d = SEQ_INTR;
        end else if (HALT_REQ) begin
          state_d = SEQ_HALT;
        end else begin
          state_d = SEQ_FETCH;
        end
      end
      SEQ_INTR: begin
        state_d = SEQ_FETCH;
      end
      SEQ_HALT: begin
        // A latched bus error masks interrupts until RUN clears it
        if (irq_take && !err_q) begin
          state_d = SEQ_INTR;
        end else if (RUN) begin
          err_d   = 1'b0;
          state_d = SEQ_FETCH;
        end
      end
      default: begin
        state_d = SEQ_RST;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= SEQ_RST;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  assign FETCH       = state_q[SEQ_FETCH_BIT];
  assign DECODE      = state_q[SEQ_DECODE_BIT];
  assign EXECUTE     = state_q[SEQ_EXECUTE_BIT];
  assign COMMIT      = state_q[SEQ_COMMIT_BIT];
  assign INT_ACK     = state_q[SEQ_INTR_BIT];
  assign HALTED      = state_q[SEQ_HALT_BIT];
  assign IR_LOAD     = state_q[SEQ_FETCH_BIT] && !BUS_WAIT;
  assign BUS_ERR     = err_q;
  assign INSTR_COUNT = count_q;

endmodule

// File: tb/tb_instruction_phase_sequencer.sv
// Directed bench for the phase sequencer (WAIT_TIMEOUT=4).
// Phase vector below is {FETCH,DECODE,EXECUTE,COMMIT}.
module tb_instruction_phase_sequencer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        BUS_WAIT;
  logic        MEM_RD;
  logic        IRQ;
  logic        IE;
  logic        HALT_REQ;
  logic        RUN;
  logic        FETCH;
  logic        DECODE;
  logic        EXECUTE;
  logic        COMMIT;
  logic        IR_LOAD;
  logic        INT_ACK;
  logic        HALTED;
  logic        BUS_ERR;
  logic [15:0] INSTR_COUNT;

  int checks = 0;
  int failures = 0;

  instruction_phase_sequencer #(
    .WAIT_TIMEOUT(4),
    .COUNT_W(16)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .BUS_WAIT   (BUS_WAIT),
    .MEM_RD     (MEM_RD),
    .IRQ        (IRQ),
    .IE         (IE),
    .HALT_REQ   (HALT_REQ),
    .RUN        (RUN),
    .FETCH      (FETCH),
    .DECODE     (DECODE),
    .EXECUTE    (EXECUTE),
    .COMMIT     (COMMIT),
    .IR_LOAD    (IR_LOAD),
    .INT_ACK    (INT_ACK),
    .HALTED     (HALTED),
    .BUS_ERR    (BUS_ERR),
    .INSTR_COUNT(INSTR_COUNT)
  );

  always #5 CLK = ~CLK;

  logic [3:0] ph;
  assign ph = {FETCH, DECODE, EXECUTE, COMMIT};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge CLK);
  endtask

  initial begin
    RESET = 1'b0;
    BUS_WAIT = 1'b0;
    MEM_RD = 1'b0;
    IRQ = 1'b0;
    IE = 1'b0;
    HALT_REQ = 1'b0;
    RUN = 1'b0;

    nxt(); #1;
    chk("rst_phase", 32'(ph), 32'h0);
    chk("rst_irload", 32'(IR_LOAD), 32'h0);
    chk("rst_intack", 32'(INT_ACK), 32'h0);
    chk("rst_halted", 32'(HALTED), 32'h0);
    chk("rst_buserr", 32'(BUS_ERR), 32'h0);
    chk("rst_count", 32'(INSTR_COUNT), 32'h0);
    RESET = 1'b1;

    for (int i = 0; i < 12; i++) begin
      nxt(); #1;
      chk($sformatf("seq_phase%0d", i), 32'(ph),
          32'(4'b1000 >> (i % 4)));
      chk($sformatf("seq_irload%0d", i), 32'(IR_LOAD),
          32'((i % 4) == 0));
    end

    nxt(); BUS_WAIT = 1'b1; #1;
    chk("cnt_after12", 32'(INSTR_COUNT), 32'd3);
    chk("fw1_phase", 32'(ph), 32'h8);
    chk("fw1_irload", 32'(IR_LOAD), 32'h0);
    nxt(); #1;
    chk("fw2_phase", 32'(ph), 32'h8);
    chk("fw2_irload", 32'(IR_LOAD), 32'h0);
    nxt(); #1;
    chk("fw3_phase", 32'(ph), 32'h8);
    chk("fw3_irload", 32'(IR_LOAD), 32'h0);
    nxt(); BUS_WAIT = 1'b0; #1;
    chk("fw4_phase", 32'(ph), 32'h8);
    chk("fw4_irload", 32'(IR_LOAD), 32'h1);
    nxt(); #1;
    chk("fw_decode", 32'(ph), 32'h4);
    chk("fw_buserr", 32'(BUS_ERR), 32'h0);

    nxt(); MEM_RD = 1'b1; BUS_WAIT = 1'b1; #1;
    chk("ew1_phase", 32'(ph), 32'h2);
    nxt(); #1;
    chk("ew2_phase", 32'(ph), 32'h2);
    nxt(); BUS_WAIT = 1'b0; #1;
    chk("ew3_phase", 32'(ph), 32'h2);
    nxt(); MEM_RD = 1'b0; #1;
    chk("ew_commit", 32'(ph), 32'h1);
    chk("ew_count", 32'(INSTR_COUNT), 32'd3);

    nxt(); #1;
    chk("nr_fetch", 32'(ph), 32'h8);
    chk("nr_count", 32'(INSTR_COUNT), 32'd4);
    nxt(); #1;
    chk("nr_decode", 32'(ph), 32'h4);
    nxt(); BUS_WAIT = 1'b1; #1;
    chk("nr_exec", 32'(ph), 32'h2);
    nxt(); BUS_WAIT = 1'b0; IRQ = 1'b1; IE = 1'b1;
    HALT_REQ = 1'b1; #1;
    chk("nr_commit", 32'(ph), 32'h1);

    nxt(); IRQ = 1'b0; HALT_REQ = 1'b0; #1;
    chk("intr_phase", 32'(ph), 32'h0);
    chk("intr_ack", 32'(INT_ACK), 32'h1);
    chk("intr_halted", 32'(HALTED), 32'h0);
    chk("intr_count", 32'(INSTR_COUNT), 32'd5);
    nxt(); #1;
    chk("intr_fetch", 32'(ph), 32'h8);
    chk("intr_ack_off", 32'(INT_ACK), 32'h0);
    nxt(); #1;
    chk("h_decode", 32'(ph), 32'h4);
    nxt(); #1;
    chk("h_exec", 32'(ph), 32'h2);
    nxt(); HALT_REQ = 1'b1; RUN = 1'b1; #1;
    chk("h_commit", 32'(ph), 32'h1);

    nxt(); HALT_REQ = 1'b0; RUN = 1'b0; IRQ = 1'b1; IE = 1'b0; #1;
    chk("halt_halted", 32'(HALTED), 32'h1);
    chk("halt_phase", 32'(ph), 32'h0);
    chk("halt_count", 32'(INSTR_COUNT), 32'd6);
    nxt(); IRQ = 1'b0; RUN = 1'b1; #1;
    chk("halt_noie", 32'(HALTED), 32'h1);
    chk("halt_noie_ack", 32'(INT_ACK), 32'h0);
    nxt(); RUN = 1'b0; BUS_WAIT = 1'b1; #1;
    chk("run_fetch", 32'(ph), 32'h8);
    chk("run_halted", 32'(HALTED), 32'h0);

    nxt(); #1;
    chk("to2_phase", 32'(ph), 32'h8);
    nxt(); #1;
    chk("to3_phase", 32'(ph), 32'h8);
    nxt(); #1;
    chk("to4_phase", 32'(ph), 32'h8);
    chk("to4_buserr", 32'(BUS_ERR), 32'h0);
    nxt(); BUS_WAIT = 1'b0; IRQ = 1'b1; IE = 1'b1; #1;
    chk("to_buserr", 32'(BUS_ERR), 32'h1);
    chk("to_halted", 32'(HALTED), 32'h1);
    chk("to_phase", 32'(ph), 32'h0);
    chk("to_count", 32'(INSTR_COUNT), 32'd6);
    nxt(); IRQ = 1'b0; IE = 1'b0; RUN = 1'b1; #1;
    chk("err_irq_blk", 32'(HALTED), 32'h1);
    chk("err_irq_ack", 32'(INT_ACK), 32'h0);
    nxt(); RUN = 1'b0; #1;
    chk("clr_fetch", 32'(ph), 32'h8);
    chk("clr_buserr", 32'(BUS_ERR), 32'h0);

    nxt(); #1;
    chk("ar_decode", 32'(ph), 32'h4);
    nxt(); MEM_RD = 1'b1; BUS_WAIT = 1'b1; #1;
    chk("ar_exec", 32'(ph), 32'h2);
    #2 RESET = 1'b0;
    #1;
    chk("ar_phase", 32'(ph), 32'h0);
    chk("ar_count", 32'(INSTR_COUNT), 32'h0);
    chk("ar_halted", 32'(HALTED), 32'h0);
    chk("ar_irload", 32'(IR_LOAD), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
